otter_sram: RTL and testbench
=============================

# otter_sram

Dual-port, word-organised, byte-addressable synchronous RAM for the OTTER multicycle RV32 core. Port A is a read-only instruction fetch port. Port B is a data load/store port supporting byte, halfword and word accesses with optional sign extension. The block sits beside `core` in the CPU wrapper and is preloaded by simulation through the hierarchical array `mem`.

## Interface
Parameters:
- `DEPTH`, 16384: number of 32-bit words (64 KiB); must be a power of two.
- `AW`, $clog2(DEPTH): word-index width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset (asserted when 0).
- `read_A` in 1: instruction read request.
- `addr_A` in 32: instruction byte address; word index is `addr_A[AW+1:2]`.
- `data_A` out 32: instruction word, registered.
- `read_B` in 1: data read request.
- `write_B` in 1: data write request.
- `sign_B` in 1: 1 sign-extends sub-word reads; 0 zero-extends them.
- `size_B` in 2: access size; 00 is byte, 01 is halfword, 10 is word, 11 is treated as word.
- `addr_B` in 32: data byte address.
- `wr_data_B` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rd_data_B` out 32: load data, registered, right-aligned and extended.

Storage is `logic [31:0] mem [0:DEPTH-1]`. The name and shape are fixed for `$readmemh` and signature dumps.

## Operation
- Reset (`rst`=0 at a rising edge):
  - `data_A` and `rd_data_B` are cleared to 0.
  - Writes are suppressed.
  - `mem` is not modified, so preloaded content survives reset.
- Port A:
  - When `read_A`=1, `data_A` is loaded with `mem[addr_A[AW+1:2]]`.
  - `addr_A[1:0]` is ignored.
  - When `read_A`=0, `data_A` holds its previous value.
- Port B write (`write_B`=1), little-endian byte enables:
  - Byte: writes lane `addr_B[1:0]` from `wr_data_B[7:0]`.
  - Half: writes lanes {1,0} when `addr_B[1]`=0, lanes {3,2} when `addr_B[1]`=1, from `wr_data_B[15:0]`. `addr_B[0]` is ignored.
  - Word: writes all lanes; `addr_B[1:0]` is ignored.
  - Unwritten lanes keep their contents.
- Port B read (`read_B`=1 and `write_B`=0):
  - Selects the same lane(s) as a write of that size.
  - Shifts the selected data to bit 0.
  - Extends per `sign_B` and registers the result into `rd_data_B`.
  - Word reads ignore `sign_B`.
- Both `read_B` and `write_B` at 1: the write is performed, the read is ignored, and `rd_data_B` holds.
- Neither asserted: `rd_data_B` holds.
- Accesses never span a word boundary; misaligned addresses are resolved only by the lane rules above.
- Address bits above `AW+1` are ignored: the address wraps modulo `DEPTH*4`. This applies unless `SRAM_BOUNDS_CHECK_EN` is defined.

## Timing
- Read latency is 1 cycle on both ports: request at edge N, data valid after edge N until the next load.
- Write latency is 1 cycle: commits at the rising edge where `write_B`=1. A port-B read of that address from edge N+1 returns the new data.
- Same-cycle port A read and port B write to the same word: port A returns the old word (read-before-write).
- No handshake and no stall: every request is accepted every cycle.
- Reset mid-operation: any read or write presented in the reset cycle is dropped, and the outputs read 0 after that edge.

## Configuration
- `SRAM_BOUNDS_CHECK_EN`:
  - Defined: any access with `addr >= DEPTH*4` is out of range. Out-of-range writes are dropped. Out-of-range reads load 0 into the respective output. In simulation, a `$display` warning is emitted with the address.
  - Undefined: addresses wrap modulo `DEPTH*4` with no check.

## Test plan
- Preload `mem[0]`=0x00000513, `mem[1]`=0x00100593; `read_A`=1 with `addr_A`=0x0 then 0x4 -> `data_A` reads 0x00000513 then 0x00100593, each one cycle after its request.
- Word write 0xDEADBEEF to 0x100, then byte read at 0x101:
  - `sign_B`=1 -> `rd_data_B`=0xFFFFFFBE.
  - `sign_B`=0 -> `rd_data_B`=0x000000BE.
- Byte write 0x55 to 0x102 over word 0x11223344 -> word reads 0x11553344. A half write of 0xA5A5 to 0x100 then gives 0x1155A5A5.
- Halfword read at 0x102 of 0x80001234 with `sign_B`=1 -> 0xFFFF8000; with `sign_B`=0 -> 0x00008000.
- Same cycle: port A reads 0x200 (old value 0x0) while port B writes 0xCAFEF00D to 0x200 -> `data_A`=0x0. The next port A read of 0x200 returns 0xCAFEF00D.
- Reset and boundary:
  - Hold `rst`=0 with `write_B`=1 -> `mem` is unchanged and both outputs are 0.
  - With `SRAM_BOUNDS_CHECK_EN` defined, a read at `DEPTH*4` -> 0.
  - Without it, a read at `DEPTH*4` returns `mem[0]`.

Source files
------------

// File: rtl/otter_sram.sv
// Dual-port byte-addressable synchronous RAM for the OTTER core: port A fetches instructions, port B does loads and stores.
// Optional macro SRAM_BOUNDS_CHECK_EN: drop out-of-range writes and return 0 for out-of-range reads instead of wrapping.
module otter_sram #(
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_A,
  input  logic [31:0] addr_A,
  output logic [31:0] data_A,
  input  logic        read_B,
  input  logic        write_B,
  input  logic        sign_B,
  input  logic [1:0]  size_B,
  input  logic [31:0] addr_B,
  input  logic [31:0] wr_data_B,
  output logic [31:0] rd_data_B
);

  localparam int unsigned LANES = 4;

  logic [31:0] mem [0:DEPTH-1];

  logic [31:0]   r_data_A;
  logic [31:0]   r_rd_data_B;
  logic [AW-1:0] w_idx_A;
  logic [AW-1:0] w_idx_B;
  logic          w_oob_A;
  logic          w_oob_B;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rword;
  logic [1:0]    w_lane;
  logic [31:0]   w_shift;
  logic [31:0]   w_rd_ext;
  logic          w_unused_lo;

  assign w_idx_A     = addr_A[AW+1:2];
  assign w_idx_B     = addr_B[AW+1:2];
  assign w_unused_lo = ^addr_A[1:0];

`ifdef SRAM_BOUNDS_CHECK_EN
  assign w_oob_A = |addr_A[31:AW+2];
  assign w_oob_B = |addr_B[31:AW+2];

`ifndef SYNTHESIS
  // Simulation-only warning for accesses beyond the array
  always_ff @(posedge clk) begin
    if (rst && read_A && w_oob_A)
      $display("otter_sram warning: port A out-of-range read at 0x%08h", addr_A);
    if (rst && (read_B || write_B) && w_oob_B)
      $display("otter_sram warning: port B out-of-range access at 0x%08h", addr_B);
  end
`endif
`else
  logic w_unused_hi;
  assign w_oob_A     = 1'b0;
  assign w_oob_B     = 1'b0;
  assign w_unused_hi = ^{addr_A[31:AW+2], addr_B[31:AW+2]};
`endif

  // Little-endian lane enables with store data replicated across lanes
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = wr_data_B;
    case (size_B)
      2'b00: begin
        w_be    = 4'(4'b0001 << addr_B[1:0]);
        w_wdata = {4{wr_data_B[7:0]}};
      end
      2'b01: begin
        w_be    = addr_B[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wr_data_B[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  assign w_we = rst & write_B & ~w_oob_B;

  // Storage is never reset so preloaded images survive
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_be[i]) mem[w_idx_B][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Load path: pick lane, shift to bit 0, extend
  assign w_rword = mem[w_idx_B];

  always_comb begin
    w_lane = 2'b00;
    case (size_B)
      2'b00:   w_lane = addr_B[1:0];
      2'b01:   w_lane = {addr_B[1], 1'b0};
      default: w_lane = 2'b00;
    endcase
  end

  assign w_shift = w_rword >> {w_lane, 3'b000};

  always_comb begin
    w_rd_ext = w_shift;
    case (size_B)
      2'b00:   w_rd_ext = {{24{sign_B & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_rd_ext = {{16{sign_B & w_shift[15]}}, w_shift[15:0]};
      default: w_rd_ext = w_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data_A    <= 32'h0;
      r_rd_data_B <= 32'h0;
    end else begin
      if (read_A)
        r_data_A <= w_oob_A ? 32'h0 : mem[w_idx_A];
      if (read_B && !write_B)
        r_rd_data_B <= w_oob_B ? 32'h0 : w_rd_ext;
    end
  end

  assign data_A    = r_data_A;
  assign rd_data_B = r_rd_data_B;

endmodule

// File: tb/tb_otter_sram.sv
// Directed self-checking bench for otter_sram covering fetch, sub-word load/store, read-before-write, reset and wrap.
module tb_otter_sram;

  logic        clk;
  logic        rst;
  logic        read_A;
  logic [31:0] addr_A;
  logic [31:0] data_A;
  logic        read_B;
  logic        write_B;
  logic        sign_B;
  logic [1:0]  size_B;
  logic [31:0] addr_B;
  logic [31:0] wr_data_B;
  logic [31:0] rd_data_B;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SRAM_BOUNDS_CHECK_EN
  localparam logic [31:0] WRAP_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] WRAP_EXP = 32'h0000_0513;
`endif

  otter_sram dut (
    .clk       (clk),
    .rst       (rst),
    .read_A    (read_A),
    .addr_A    (addr_A),
    .data_A    (data_A),
    .read_B    (read_B),
    .write_B   (write_B),
    .sign_B    (sign_B),
    .size_B    (size_B),
    .addr_B    (addr_B),
    .wr_data_B (wr_data_B),
    .rd_data_B (rd_data_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    write_B = 1'b1; addr_B = a; wr_data_B = d; size_B = sz;
    tick();
    write_B = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    read_B = 1'b1; addr_B = a; size_B = sz; sign_B = sg;
    tick();
    read_B = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    read_A = 1'b1; addr_A = a;
    tick();
    read_A = 1'b0;
  endtask

  initial begin
    rst = 1'b0; read_A = 1'b0; addr_A = '0; read_B = 1'b0; write_B = 1'b0;
    sign_B = 1'b0; size_B = 2'b10; addr_B = '0; wr_data_B = '0;
    dut.mem[0]   = 32'h0000_0513;
    dut.mem[1]   = 32'h0010_0593;
    dut.mem[128] = 32'h0000_0000;

    // Reset with requests pending: write dropped, outputs cleared
    write_B = 1'b1; addr_B = 32'h0; wr_data_B = 32'hFFFF_FFFF; size_B = 2'b10;
    read_A = 1'b1; addr_A = 32'h4;
    tick();
    tick();
    check("rst_data_A", data_A, 32'h0);
    check("rst_rd_data_B", rd_data_B, 32'h0);
    write_B = 1'b0; read_A = 1'b0; rst = 1'b1;

    // Instruction fetch
    fetch(32'h0);
    check("fetch_0", data_A, 32'h0000_0513);
    fetch(32'h4);
    check("fetch_4", data_A, 32'h0010_0593);
    addr_A = 32'h0; tick();
    check("fetch_hold", data_A, 32'h0010_0593);
    fetch(32'h7);
    check("fetch_misalign", data_A, 32'h0010_0593);

    // Byte loads with sign/zero extension
    store(32'h100, 32'hDEAD_BEEF, 2'b10);
    load(32'h101, 2'b00, 1'b1);
    check("lb_0x101", rd_data_B, 32'hFFFF_FFBE);
    load(32'h101, 2'b00, 1'b0);
    check("lbu_0x101", rd_data_B, 32'h0000_00BE);
    load(32'h103, 2'b11, 1'b1);
    check("lw_size11", rd_data_B, 32'hDEAD_BEEF);

    // Sub-word stores merge into the word
    store(32'h100, 32'h1122_3344, 2'b10);
    store(32'h102, 32'hFFFF_FF55, 2'b00);
    load(32'h100, 2'b10, 1'b0);
    check("sb_merge", rd_data_B, 32'h1155_3344);
    store(32'h100, 32'h0000_A5A5, 2'b01);
    load(32'h100, 2'b10, 1'b0);
    check("sh_low", rd_data_B, 32'h1155_A5A5);
    store(32'h103, 32'h0000_7788, 2'b01);
    load(32'h100, 2'b10, 1'b1);
    check("sh_high_odd", rd_data_B, 32'h7788_A5A5);

    // Halfword loads
    store(32'h108, 32'h8000_1234, 2'b10);
    load(32'h10A, 2'b01, 1'b1);
    check("lh_0x10a", rd_data_B, 32'hFFFF_8000);
    load(32'h10A, 2'b01, 1'b0);
    check("lhu_0x10a", rd_data_B, 32'h0000_8000);
    load(32'h109, 2'b01, 1'b1);
    check("lh_0x109", rd_data_B, 32'h0000_1234);

    // Port A read-before-write against port B store
    read_A = 1'b1; addr_A = 32'h200;
    write_B = 1'b1; addr_B = 32'h200; wr_data_B = 32'hCAFE_F00D; size_B = 2'b10;
    tick();
    read_A = 1'b0; write_B = 1'b0;
    check("rbw_old", data_A, 32'h0);
    fetch(32'h200);
    check("rbw_new", data_A, 32'hCAFE_F00D);

    // Read and write together: write wins, load data holds
    read_B = 1'b1; write_B = 1'b1; addr_B = 32'h300; wr_data_B = 32'h1234_5678; size_B = 2'b10;
    tick();
    read_B = 1'b0; write_B = 1'b0;
    check("rw_hold", rd_data_B, 32'h0000_1234);
    load(32'h300, 2'b10, 1'b0);
    check("rw_written", rd_data_B, 32'h1234_5678);

    // Address at DEPTH*4
    fetch(32'h0001_0000);
    check("wrap_A", data_A, WRAP_EXP);
    load(32'h0001_0000, 2'b10, 1'b0);
    check("wrap_B", rd_data_B, WRAP_EXP);

    // Mid-operation reset
    fetch(32'h4);
    load(32'h300, 2'b10, 1'b0);
    rst = 1'b0; read_A = 1'b1; read_B = 1'b1; addr_A = 32'h4; addr_B = 32'h300;
    tick();
    check("midrst_data_A", data_A, 32'h0);
    check("midrst_rd_data_B", rd_data_B, 32'h0);
    rst = 1'b1; read_A = 1'b0; read_B = 1'b0;
    fetch(32'h0);
    check("post_rst_mem0", data_A, 32'h0000_0513);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
